// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-vote helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-output bundle from the UART receiver to the boot loader parser.
interface uart_rx_if;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;
  logic       busy;

  modport master (output dout, output dout_valid, output frame_err, output busy);
  modport slave  (input  dout, input  dout_valid, input  frame_err, input  busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider; one-cycle tick every DIV enabled cycles.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)     cnt <= '0;
    else if (ce) cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign tick = ce && (cnt == LAST);
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, OVS oversampling with 3-sample
// majority vote around mid-bit, framing-error detection and break hold-off.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 16_000_000,
  parameter int BAUD     = 115_200,
  parameter int OVS      = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         rx,
  uart_rx_if.master    bus
);
  localparam int DIV = CLK_FREQ / (BAUD * OVS);
  localparam int SW  = $clog2(OVS);

  localparam logic [SW-1:0] S_LO = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] S_MD = SW'(OVS/2);
  localparam logic [SW-1:0] S_HI = SW'(OVS/2 + 1);
  localparam logic [SW-1:0] LAST = SW'(OVS - 1);

  if (DIV < 1) begin : g_div_chk
    $error("uart_rx: CLK_FREQ/(BAUD*OVS) must be >= 1");
  end
  if ((OVS < 8) || (OVS % 2 != 0)) begin : g_ovs_chk
    $error("uart_rx: OVS must be even and >= 8");
  end

  logic tick;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .tick (tick)
  );

  uart_state_t   state;
  logic          rx_meta, rx_s;
  logic [SW-1:0] scnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic          s_a, s_b;
  logic [7:0]    dout_q;
  logic          valid_q, ferr_q, busy_q;
  logic          bit_val;

  // The third vote is the live sample taken at S_HI, when the decision is made.
  assign bit_val = maj3(s_a, s_b, rx_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      scnt    <= '0;
      bidx    <= '0;
      shreg   <= '0;
      s_a     <= 1'b1;
      s_b     <= 1'b1;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // Pulses clear regardless of ce so they never stretch.
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (ce) begin
        rx_meta <= rx;
        rx_s    <= rx_meta;
      end
      if (tick) begin
        if (state != IDLE && state != BREAK) begin
          scnt <= (scnt == LAST) ? '0 : scnt + SW'(1);
          if (scnt == S_LO) s_a <= rx_s;
          if (scnt == S_MD) s_b <= rx_s;
        end
        case (state)
          IDLE: if (!rx_s) begin
            state  <= START;
            scnt   <= '0;
            busy_q <= 1'b1;
          end
          START: begin
            if (scnt == S_HI && bit_val) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else if (scnt == LAST) begin
              state <= DATA;
              bidx  <= '0;
            end
          end
          DATA: begin
            if (scnt == S_HI) shreg <= {bit_val, shreg[7:1]};
            if (scnt == LAST) begin
              if (bidx == 3'd7) state <= STOP;
              else              bidx  <= bidx + 3'd1;
            end
          end
          STOP: if (scnt == S_HI) begin
            // Leave mid-stop-bit so the next start edge is caught at full rate.
            if (bit_val) begin
              dout_q  <= shreg;
              valid_q <= 1'b1;
              state   <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q <= 1'b1;
              state  <= BREAK;
            end
          end
          BREAK: if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=1, OVS=16 (16 clk per bit).
module tb_uart_rx;
  logic clk, rst, ce, rx;
  uart_rx_if bus();

  uart_rx #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVS(16)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .rx  (rx),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail;
  int n_valid, n_ferr, n_both;
  logic [7:0] rxq[$];
  bit ce_tog;
  logic busy_mid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.dout_valid) begin
      rxq.push_back(bus.dout);
      n_valid++;
    end
    if (bus.frame_err) n_ferr++;
    if (bus.dout_valid && bus.frame_err) n_both++;
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
    if (ce_tog) ce = ~ce;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) tick_clk();
  endtask

  // Value set before edge i of the bit; optional 1-clk spike lands on the scnt=OVS/2 vote.
  task automatic send_bit(input logic v, input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      rx = (noisy && i == 9) ? ~v : v;
      tick_clk();
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int bclk, input bit noisy);
    send_bit(1'b0, bclk, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i], bclk, noisy);
      if (i == 0) busy_mid = bus.busy;
    end
    send_bit(stop_v, bclk, 1'b0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    rx  = 1'b1;
    ce  = 1'b1;
    for (int i = 0; i < 3; i++) tick_clk();
    rst = 1'b0;
    tick_clk();
  endtask

  int v0, f0;

  initial begin
    n_chk = 0; n_fail = 0; n_valid = 0; n_ferr = 0; n_both = 0;
    ce_tog = 1'b0; busy_mid = 1'b0;
    apply_reset();
    chk("rst_dout",  32'(bus.dout), 32'h00);
    chk("rst_valid", 32'(bus.dout_valid), 0);
    chk("rst_ferr",  32'(bus.frame_err), 0);
    chk("rst_busy",  32'(bus.busy), 0);

    // Single frame A5
    idle(10);
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, 1'b1, 16, 1'b0);
    chk("a5_busy_mid", 32'(busy_mid), 1);
    chk("a5_busy_end", 32'(bus.busy), 0);
    idle(20);
    chk("a5_nvalid", 32'(n_valid - v0), 1);
    chk("a5_dout",   32'(bus.dout), 32'hA5);
    chk("a5_ferr",   32'(n_ferr - f0), 0);

    // Back-to-back frames, no idle gap
    rxq.delete();
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h00, 1'b1, 16, 1'b0);
    send_frame(8'hFF, 1'b1, 16, 1'b0);
    send_frame(8'h55, 1'b1, 16, 1'b0);
    idle(30);
    chk("b2b_nvalid", 32'(n_valid - v0), 3);
    chk("b2b_ferr",   32'(n_ferr - f0), 0);
    if (rxq.size() == 3) begin
      chk("b2b_q0", 32'(rxq[0]), 32'h00);
      chk("b2b_q1", 32'(rxq[1]), 32'hFF);
      chk("b2b_q2", 32'(rxq[2]), 32'h55);
    end else begin
      chk("b2b_qsize", 32'(rxq.size()), 3);
    end

    // 4-clk glitch on idle line
    v0 = n_valid; f0 = n_ferr;
    send_bit(1'b0, 4, 1'b0);
    rx = 1'b1;
    chk("glitch_busy_hi", 32'(bus.busy), 1);
    for (int i = 0; i < 10; i++) tick_clk();
    chk("glitch_busy_lo", 32'(bus.busy), 0);
    idle(40);
    chk("glitch_nvalid", 32'(n_valid - v0), 0);
    chk("glitch_ferr",   32'(n_ferr - f0), 0);

    // Framing error then break, then a good frame
    apply_reset();
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 16, 1'b0);
    send_bit(1'b0, 40, 1'b0);
    chk("brk_ferr",   32'(n_ferr - f0), 1);
    chk("brk_nvalid", 32'(n_valid - v0), 0);
    chk("brk_dout",   32'(bus.dout), 32'h00);
    chk("brk_busy",   32'(bus.busy), 1);
    idle(20);
    send_frame(8'h81, 1'b1, 16, 1'b0);
    idle(20);
    chk("brk_nvalid2", 32'(n_valid - v0), 1);
    chk("brk_dout2",   32'(bus.dout), 32'h81);
    chk("brk_ferr2",   32'(n_ferr - f0), 1);

    // Single-sample spike inside each data bit
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h96, 1'b1, 16, 1'b1);
    idle(20);
    chk("noise_nvalid", 32'(n_valid - v0), 1);
    chk("noise_dout",   32'(bus.dout), 32'h96);
    chk("noise_ferr",   32'(n_ferr - f0), 0);

    // Reset mid-DATA aborts the frame
    v0 = n_valid; f0 = n_ferr;
    send_bit(1'b0, 16, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 16, 1'b0);
    rst = 1'b1;
    rx  = 1'b1;
    tick_clk();
    rst = 1'b0;
    idle(200);
    chk("rstmid_nvalid", 32'(n_valid - v0), 0);
    chk("rstmid_ferr",   32'(n_ferr - f0), 0);
    chk("rstmid_dout",   32'(bus.dout), 32'h00);
    chk("rstmid_busy",   32'(bus.busy), 0);
    send_frame(8'h5A, 1'b1, 16, 1'b0);
    idle(20);
    chk("rstmid_nvalid2", 32'(n_valid - v0), 1);
    chk("rstmid_dout2",   32'(bus.dout), 32'h5A);

    // ce at 50% duty, line at half baud
    v0 = n_valid; f0 = n_ferr;
    ce_tog = 1'b1;
    send_frame(8'hC3, 1'b1, 32, 1'b0);
    idle(40);
    ce_tog = 1'b0;
    ce = 1'b1;
    idle(10);
    chk("ce_nvalid", 32'(n_valid - v0), 1);
    chk("ce_dout",   32'(bus.dout), 32'hC3);
    chk("ce_ferr",   32'(n_ferr - f0), 0);

    chk("valid_ferr_overlap", 32'(n_both), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
